// File: rtl/lcd_pkg.sv
// ---------------------------------------------------------------------------
// lcd_pkg -- shared types and constants for the HD44780-style LCD write
// controller (lcd_write_ctrl, lcd_timer, lcd_write_ctrl_if).
//
// Contents:
//   lcd_state_e   controller state encoding
//   CMD_*         command bytes the controller itself recognises or issues
//   INIT_CMDS     power-up command table, used when LCD_INIT_SEQ_EN is defined
//   next_cursor   cursor update rule for one byte written to the panel
//   is_long_wait  selects the long post-write wait (clear / home)
//   cnt_width     timer width able to hold the largest wait count
// ---------------------------------------------------------------------------
package lcd_pkg;

    typedef enum logic [2:0] {
        ST_PWR_WAIT,
        ST_INIT,
        ST_IDLE,
        ST_SETUP,
        ST_PULSE,
        ST_HOLD,
        ST_WAIT,
        ST_AUTO
    } lcd_state_e;

    localparam int CURSOR_W = 5;

    localparam logic [7:0] CMD_CLEAR = 8'h01;
    localparam logic [7:0] CMD_HOME  = 8'h02;
    localparam logic [7:0] CMD_LINE1 = 8'h80;
    localparam logic [7:0] CMD_LINE2 = 8'hC0;

    // Function set 8-bit/2-line (three times), display on, entry mode, clear.
    // Entry 0 is issued first.
    localparam int INIT_LEN = 6;
    localparam logic [INIT_LEN-1:0][7:0] INIT_CMDS =
        {CMD_CLEAR, 8'h06, 8'h0C, 8'h38, 8'h38, 8'h38};

    // Cursor position after writing one byte. Data advances modulo 32;
    // clear/home return to 0; a DDRAM address command maps line bit 6 and
    // column bits 3:0 onto the 32-character position.
    function automatic logic [CURSOR_W-1:0] next_cursor(
        input logic [CURSOR_W-1:0] cur,
        input logic [7:0]          data,
        input logic                rs
    );
        if (rs)
            next_cursor = cur + 5'd1;
        else if (data == CMD_CLEAR || data == CMD_HOME)
            next_cursor = '0;
        else if (data[7])
            next_cursor = {data[6], data[3:0]};
        else
            next_cursor = cur;
    endfunction

    function automatic logic is_long_wait(input logic [7:0] data, input logic rs);
        return !rs && (data == CMD_CLEAR || data == CMD_HOME);
    endfunction

    function automatic int cnt_width(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/lcd_write_ctrl_if.sv
// ---------------------------------------------------------------------------
// lcd_write_ctrl_if -- request handshake and LCD pin bundle.
//
//   req_valid  request present            (master -> slave)
//   req_ready  controller can accept      (slave -> master)
//   req_data   byte to write              (master -> slave)
//   req_rs     1 = data, 0 = command      (master -> slave)
//   lcd_db     LCD data bus               (slave out)
//   lcd_rs     LCD register select        (slave out)
//   lcd_rw     LCD read/write, always 0   (slave out)
//   lcd_e      LCD enable strobe          (slave out)
//   busy       !req_ready                 (slave out)
//   cursor     character position 0..31   (slave out)
//
// The slave modport is the controller; the master modport is its client.
// ---------------------------------------------------------------------------
interface lcd_write_ctrl_if;
    import lcd_pkg::*;

    logic                req_valid;
    logic                req_ready;
    logic [7:0]          req_data;
    logic                req_rs;
    logic [7:0]          lcd_db;
    logic                lcd_rs;
    logic                lcd_rw;
    logic                lcd_e;
    logic                busy;
    logic [CURSOR_W-1:0] cursor;

    modport master (
        output req_valid, req_data, req_rs,
        input  req_ready, lcd_db, lcd_rs, lcd_rw, lcd_e, busy, cursor
    );

    modport slave (
        input  req_valid, req_data, req_rs,
        output req_ready, lcd_db, lcd_rs, lcd_rw, lcd_e, busy, cursor
    );

endinterface

// File: rtl/lcd_timer.sv
// ---------------------------------------------------------------------------
// lcd_timer -- loadable down-counter shared by the power-up wait, the E pulse
// and the post-write wait.
//
//   clk         system clock
//   rst_n       asynchronous active-low reset (counter takes RST_VAL)
//   load_i      load load_val_i on this edge
//   load_val_i  number of cycles to run
//   done_o      high during the last cycle of the count (and when idle)
//
// A count of N loaded at edge L raises done_o during the cycle before edge
// L+N, so a state that leaves on done_o occupies exactly N cycles.
// ---------------------------------------------------------------------------
module lcd_timer #(
    parameter int          W       = 8,
    parameter int unsigned RST_VAL = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         done_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= W'(RST_VAL);
        else if (load_i)
            cnt_q <= load_val_i;
        else if (cnt_q != '0)
            cnt_q <= cnt_q - 1'b1;
    end

    assign done_o = (cnt_q <= W'(1));

endmodule

// File: rtl/lcd_write_ctrl.sv
// ---------------------------------------------------------------------------
// lcd_write_ctrl -- writes command/data bytes to an HD44780-style character
// LCD in 8-bit mode, generating the E strobe and the post-write waits, and
// tracking the cursor across a 2x16 display (wrapping lines automatically).
//
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    lcd_write_ctrl_if.slave: req_valid/req_ready/req_data/req_rs
//          handshake in, lcd_db/lcd_rs/lcd_rw/lcd_e pins, busy, cursor out
//
// Parameters (in clk cycles): E_PULSE_CYC, CMD_WAIT_CYC, CLR_WAIT_CYC,
// PWR_WAIT_CYC.
//
// Build option LCD_INIT_SEQ_EN: when defined, reset leads to a power-up wait
// followed by the INIT_CMDS sequence before IDLE; otherwise reset leads
// straight to IDLE.
// ---------------------------------------------------------------------------
module lcd_write_ctrl
    import lcd_pkg::*;
#(
    parameter int E_PULSE_CYC  = 12,
    parameter int CMD_WAIT_CYC = 2000,
    parameter int CLR_WAIT_CYC = 82000,
    parameter int PWR_WAIT_CYC = 750000
) (
    input  logic              clk,
    input  logic              rst_n,
    lcd_write_ctrl_if.slave   bus
);

    localparam int TW = cnt_width(E_PULSE_CYC, CMD_WAIT_CYC, CLR_WAIT_CYC, PWR_WAIT_CYC);

`ifdef LCD_INIT_SEQ_EN
    localparam int unsigned TMR_RST   = PWR_WAIT_CYC;
    localparam lcd_state_e  RST_STATE = ST_PWR_WAIT;
`else
    localparam int unsigned TMR_RST   = 0;
    localparam lcd_state_e  RST_STATE = ST_IDLE;
`endif

    lcd_state_e          state_q;
    logic [7:0]          db_q;
    logic                rs_q;
    logic                e_q;
    logic                ready_q;
    logic [CURSOR_W-1:0] cursor_q;
    logic                long_wait_q;   // captured byte needs CLR_WAIT_CYC
    logic                auto_pend_q;   // a line-change command follows
    logic [7:0]          auto_cmd_q;
`ifdef LCD_INIT_SEQ_EN
    logic [2:0]          init_idx_q;
`endif

    // Byte capture: one source per state that starts a write.
    logic                cap_en;
    logic [7:0]          cap_data;
    logic                cap_rs;
    logic [CURSOR_W-1:0] cursor_d;

    always_comb begin
        cap_en   = 1'b0;
        cap_data = bus.req_data;
        cap_rs   = bus.req_rs;
        case (state_q)
            ST_IDLE: cap_en = ready_q && bus.req_valid;
            ST_AUTO: begin
                cap_en   = 1'b1;
                cap_data = auto_cmd_q;
                cap_rs   = 1'b0;
            end
`ifdef LCD_INIT_SEQ_EN
            ST_INIT: begin
                cap_en   = 1'b1;
                cap_data = INIT_CMDS[init_idx_q];
                cap_rs   = 1'b0;
            end
`endif
            default: ;
        endcase
        cursor_d = next_cursor(cursor_q, cap_data, cap_rs);
    end

    // Timer loads on the single-cycle SETUP and HOLD states so that PULSE
    // and WAIT each last exactly their programmed number of cycles.
    logic          tmr_load;
    logic [TW-1:0] tmr_val;
    logic          tmr_done;

    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = '0;
        if (state_q == ST_SETUP) begin
            tmr_load = 1'b1;
            tmr_val  = TW'(E_PULSE_CYC);
        end else if (state_q == ST_HOLD) begin
            tmr_load = 1'b1;
            tmr_val  = long_wait_q ? TW'(CLR_WAIT_CYC) : TW'(CMD_WAIT_CYC);
        end
    end

    lcd_timer #(
        .W       (TW),
        .RST_VAL (TMR_RST)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .done_o     (tmr_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RST_STATE;
            db_q        <= 8'h00;
            rs_q        <= 1'b0;
            e_q         <= 1'b0;
            ready_q     <= 1'b0;
            cursor_q    <= '0;
            long_wait_q <= 1'b0;
            auto_pend_q <= 1'b0;
            auto_cmd_q  <= 8'h00;
`ifdef LCD_INIT_SEQ_EN
            init_idx_q  <= 3'd0;
`endif
        end else begin
            // The bus is only rewritten at capture, so it stays stable from
            // SETUP through HOLD and beyond.
            if (cap_en) begin
                db_q        <= cap_data;
                rs_q        <= cap_rs;
                cursor_q    <= cursor_d;
                long_wait_q <= is_long_wait(cap_data, cap_rs);
                auto_pend_q <= cap_rs && (cursor_d == 5'd16 || cursor_d == 5'd0);
                auto_cmd_q  <= (cursor_d == 5'd0) ? CMD_LINE1 : CMD_LINE2;
            end

            case (state_q)
                ST_PWR_WAIT: if (tmr_done) state_q <= ST_INIT;
                ST_INIT: begin
`ifdef LCD_INIT_SEQ_EN
                    init_idx_q <= init_idx_q + 3'd1;
                    state_q    <= ST_SETUP;
`else
                    state_q    <= ST_IDLE;
`endif
                end
                ST_IDLE: begin
                    if (cap_en) begin
                        ready_q <= 1'b0;
                        state_q <= ST_SETUP;
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                ST_SETUP: begin
                    e_q     <= 1'b1;
                    state_q <= ST_PULSE;
                end
                ST_PULSE: begin
                    if (tmr_done) begin
                        e_q     <= 1'b0;
                        state_q <= ST_HOLD;
                    end
                end
                ST_HOLD: state_q <= ST_WAIT;
                ST_WAIT: begin
                    if (tmr_done) begin
                        if (auto_pend_q)
                            state_q <= ST_AUTO;
`ifdef LCD_INIT_SEQ_EN
                        else if (init_idx_q != 3'(INIT_LEN))
                            state_q <= ST_INIT;
`endif
                        else begin
                            ready_q <= 1'b1;
                            state_q <= ST_IDLE;
                        end
                    end
                end
                ST_AUTO: state_q <= ST_SETUP;
                default: state_q <= RST_STATE;
            endcase
        end
    end

    assign bus.req_ready = ready_q;
    assign bus.busy      = ~ready_q;
    assign bus.lcd_db    = db_q;
    assign bus.lcd_rs    = rs_q;
    assign bus.lcd_rw    = 1'b0;
    assign bus.lcd_e     = e_q;
    assign bus.cursor    = cursor_q;

endmodule

// File: tb/tb_lcd_write_ctrl.sv
// ---------------------------------------------------------------------------
// tb_lcd_write_ctrl -- directed bench for lcd_write_ctrl with
// E_PULSE_CYC=2, CMD_WAIT_CYC=4, CLR_WAIT_CYC=10, PWR_WAIT_CYC=20.
// Follows LCD_INIT_SEQ_EN the same way the design does.
// Sample point k counts edges after the acceptance edge T (k=0 is just after
// T): lcd_e high at k=1,2, low at k=3, req_ready back at k=8 (short wait) or
// k=14 (clear/home).
// ---------------------------------------------------------------------------
module tb_lcd_write_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    lcd_write_ctrl_if bus();

    lcd_write_ctrl #(
        .E_PULSE_CYC  (2),
        .CMD_WAIT_CYC (4),
        .CLR_WAIT_CYC (10),
        .PWR_WAIT_CYC (20)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Pulse recorder: one entry per E pulse, with bus contents at the rising
    // edge, high time, and whether db/rs held through the following low cycle.
    logic [7:0] q_db[$];
    logic       q_rs[$];
    int         q_len[$];
    bit         q_ok[$];

    initial begin : monitor
        logic       in_pulse;
        logic [7:0] m_db;
        logic       m_rs;
        int         m_len;
        bit         m_ok;
        in_pulse = 1'b0;
        m_db = 8'h00; m_rs = 1'b0; m_len = 0; m_ok = 1'b1;
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                in_pulse = 1'b0;
            end else if (bus.lcd_e === 1'b1) begin
                if (!in_pulse) begin
                    in_pulse = 1'b1;
                    m_db = bus.lcd_db; m_rs = bus.lcd_rs; m_len = 0; m_ok = 1'b1;
                end
                m_len++;
                if (bus.lcd_db !== m_db || bus.lcd_rs !== m_rs) m_ok = 1'b0;
            end else if (in_pulse) begin
                if (bus.lcd_db !== m_db || bus.lcd_rs !== m_rs) m_ok = 1'b0;
                q_db.push_back(m_db); q_rs.push_back(m_rs);
                q_len.push_back(m_len); q_ok.push_back(m_ok);
                in_pulse = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_q();
        q_db.delete(); q_rs.delete(); q_len.delete(); q_ok.delete();
    endtask

    task automatic wait_ready(input int max_cyc, input string tag);
        int n = 0;
        while (bus.req_ready !== 1'b1 && n < max_cyc) begin
            tick();
            n++;
        end
        vectors++;
        if (bus.req_ready !== 1'b1) begin
            $display("FAIL %s: req_ready still %b after %0d cycles, required 1", tag, bus.req_ready, n);
            miscompares++;
        end
    endtask

    // Presents one byte, returns just after the acceptance edge (k=0), then
    // scrambles the request lines which must no longer matter.
    task automatic send(input logic [7:0] d, input logic rs);
        wait_ready(200, "send_ready");
        bus.req_valid = 1'b1;
        bus.req_data  = d;
        bus.req_rs    = rs;
        tick();
        bus.req_valid = 1'b0;
        bus.req_data  = ~d;
        bus.req_rs    = ~rs;
    endtask

    task automatic cmd(input logic [7:0] d);
        send(d, 1'b0);
        wait_ready(200, "cmd_done");
    endtask

    task automatic send_timed(input logic [7:0] d, input logic rs, input int ready_k, input string tag);
        logic exp_e, exp_r;
        send(d, rs);
        vectors++;
        if (bus.lcd_db !== d || bus.lcd_rs !== rs) begin
            $display("FAIL %s setup: db/rs %h/%b, required %h/%b", tag, bus.lcd_db, bus.lcd_rs, d, rs);
            miscompares++;
        end
        for (int k = 0; k <= ready_k; k++) begin
            exp_e = (k == 1 || k == 2);
            exp_r = (k == ready_k);
            vectors++;
            if (bus.lcd_e !== exp_e) begin
                $display("FAIL %s lcd_e k=%0d: got %b, required %b", tag, k, bus.lcd_e, exp_e);
                miscompares++;
            end
            vectors++;
            if (bus.req_ready !== exp_r) begin
                $display("FAIL %s req_ready k=%0d: got %b, required %b", tag, k, bus.req_ready, exp_r);
                miscompares++;
            end
            if (k < ready_k) tick();
        end
    endtask

    task automatic check_release();
`ifdef LCD_INIT_SEQ_EN
        logic [7:0] exp_init [6];
        bit         e_seen;
        int         n;
        exp_init = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h06, 8'h01};
`endif
        clear_q();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
`ifdef LCD_INIT_SEQ_EN
        e_seen = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            if (bus.lcd_e !== 1'b0) e_seen = 1'b1;
            if (k < 20) tick();
        end
        vectors++;
        if (e_seen !== 1'b0) begin
            $display("FAIL init_pwr_wait: lcd_e seen %b in first 20 cycles, required 0", e_seen);
            miscompares++;
        end
        n = 0;
        while ((q_db.size() < 6 || bus.req_ready !== 1'b1) && n < 300) begin
            tick();
            n++;
        end
        vectors++;
        if (q_db.size() != 6) begin
            $display("FAIL init_count: %0d pulses, required 6", q_db.size());
            miscompares++;
        end
        for (int i = 0; i < 6 && i < q_db.size(); i++) begin
            vectors++;
            if (q_db[i] !== exp_init[i] || q_rs[i] !== 1'b0 || q_len[i] != 2 || !q_ok[i]) begin
                $display("FAIL init_pulse%0d: db %h rs %b len %0d stable %b, required %h 0 2 1",
                         i, q_db[i], q_rs[i], q_len[i], q_ok[i], exp_init[i]);
                miscompares++;
            end
        end
`endif
        vectors++;
        if (bus.req_ready !== 1'b1) begin
            $display("FAIL release_ready: req_ready %b, required 1", bus.req_ready);
            miscompares++;
        end
        vectors++;
        if (bus.cursor !== 5'd0) begin
            $display("FAIL release_cursor: cursor %0d, required 0", bus.cursor);
            miscompares++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_data  = 8'h00;
        bus.req_rs    = 1'b0;
        repeat (3) tick();
        vectors++;
        if (bus.lcd_e !== 1'b0 || bus.lcd_rs !== 1'b0 || bus.lcd_rw !== 1'b0) begin
            $display("FAIL reset_pins: e/rs/rw %b%b%b, required 000", bus.lcd_e, bus.lcd_rs, bus.lcd_rw);
            miscompares++;
        end
        vectors++;
        if (bus.lcd_db !== 8'h00) begin
            $display("FAIL reset_db: db %h, required 00", bus.lcd_db);
            miscompares++;
        end
        vectors++;
        if (bus.req_ready !== 1'b0 || bus.busy !== 1'b1) begin
            $display("FAIL reset_ready: ready/busy %b/%b, required 0/1", bus.req_ready, bus.busy);
            miscompares++;
        end
        vectors++;
        if (bus.cursor !== 5'd0) begin
            $display("FAIL reset_cursor: cursor %0d, required 0", bus.cursor);
            miscompares++;
        end
        check_release();
    endtask

    task automatic test_data_write();
        clear_q();
        send_timed(8'h61, 1'b1, 8, "data61");
        vectors++;
        if (bus.cursor !== 5'd1) begin
            $display("FAIL data61_cursor: cursor %0d, required 1", bus.cursor);
            miscompares++;
        end
        vectors++;
        if (q_db.size() != 1 || q_db[0] !== 8'h61 || q_rs[0] !== 1'b1 || !q_ok[0]) begin
            $display("FAIL data61_pulse: %0d pulses, first db %h rs %b, required 1 pulse 61 1 stable",
                     q_db.size(), (q_db.size() > 0) ? q_db[0] : 8'hxx, (q_rs.size() > 0) ? q_rs[0] : 1'bx);
            miscompares++;
        end
    endtask

    task automatic test_line_wrap();
        cmd(8'h80);
        clear_q();
        for (int i = 0; i < 16; i++) send(8'h41 + 8'(i), 1'b1);
        wait_ready(200, "wrap1_done");
        vectors++;
        if (q_db.size() != 17 || q_db[16] !== 8'hC0 || q_rs[16] !== 1'b0) begin
            $display("FAIL wrap_line2: %0d pulses, last db %h rs %b, required 17 C0 0",
                     q_db.size(), q_db[q_db.size()-1], q_rs[q_rs.size()-1]);
            miscompares++;
        end
        vectors++;
        if (bus.cursor !== 5'd16) begin
            $display("FAIL wrap_cursor16: cursor %0d, required 16", bus.cursor);
            miscompares++;
        end
        clear_q();
        for (int i = 0; i < 16; i++) send(8'h61 + 8'(i), 1'b1);
        wait_ready(200, "wrap2_done");
        vectors++;
        if (q_db.size() != 17 || q_db[16] !== 8'h80 || q_rs[16] !== 1'b0) begin
            $display("FAIL wrap_line1: %0d pulses, last db %h rs %b, required 17 80 0",
                     q_db.size(), q_db[q_db.size()-1], q_rs[q_rs.size()-1]);
            miscompares++;
        end
        vectors++;
        if (bus.cursor !== 5'd0) begin
            $display("FAIL wrap_cursor0: cursor %0d, required 0", bus.cursor);
            miscompares++;
        end
        for (int i = 0; i < q_db.size(); i++) begin
            vectors++;
            if (q_len[i] != 2 || !q_ok[i]) begin
                $display("FAIL wrap_pulse%0d: len %0d stable %b, required 2 1", i, q_len[i], q_ok[i]);
                miscompares++;
            end
        end
    endtask

    task automatic test_clear_and_addr();
        cmd(8'h87);
        vectors++;
        if (bus.cursor !== 5'd7) begin
            $display("FAIL addr87: cursor %0d, required 7", bus.cursor);
            miscompares++;
        end
        send_timed(8'h01, 1'b0, 14, "clear");
        vectors++;
        if (bus.cursor !== 5'd0) begin
            $display("FAIL clear_cursor: cursor %0d, required 0", bus.cursor);
            miscompares++;
        end
        cmd(8'hC5);
        vectors++;
        if (bus.cursor !== 5'd21) begin
            $display("FAIL addrC5: cursor %0d, required 21", bus.cursor);
            miscompares++;
        end
        send_timed(8'h0C, 1'b0, 8, "disp_on");
        vectors++;
        if (bus.cursor !== 5'd21) begin
            $display("FAIL plain_cmd_cursor: cursor %0d, required 21", bus.cursor);
            miscompares++;
        end
        send_timed(8'h02, 1'b0, 14, "home");
        vectors++;
        if (bus.cursor !== 5'd0) begin
            $display("FAIL home_cursor: cursor %0d, required 0", bus.cursor);
            miscompares++;
        end
    endtask

    // req_valid held high with a new byte every cycle: accepts land on edges
    // 0, 9, 18 and 27 of a 30-edge window.
    task automatic test_back_to_back();
        logic [7:0] exp_db [4];
        exp_db = '{8'h30, 8'h39, 8'h42, 8'h4B};
        cmd(8'h80);
        clear_q();
        bus.req_valid = 1'b1;
        bus.req_rs    = 1'b1;
        for (int n = 0; n < 30; n++) begin
            bus.req_data = 8'h30 + 8'(n);
            tick();
        end
        bus.req_valid = 1'b0;
        wait_ready(200, "b2b_done");
        vectors++;
        if (q_db.size() != 4) begin
            $display("FAIL b2b_count: %0d pulses, required 4", q_db.size());
            miscompares++;
        end
        for (int i = 0; i < 4 && i < q_db.size(); i++) begin
            vectors++;
            if (q_db[i] !== exp_db[i] || q_rs[i] !== 1'b1 || q_len[i] != 2 || !q_ok[i]) begin
                $display("FAIL b2b_pulse%0d: db %h rs %b len %0d stable %b, required %h 1 2 1",
                         i, q_db[i], q_rs[i], q_len[i], q_ok[i], exp_db[i]);
                miscompares++;
            end
        end
        vectors++;
        if (bus.cursor !== 5'd4) begin
            $display("FAIL b2b_cursor: cursor %0d, required 4", bus.cursor);
            miscompares++;
        end
    endtask

    task automatic test_reset_mid_pulse();
        send(8'h55, 1'b1);
        tick();
        vectors++;
        if (bus.lcd_e !== 1'b1) begin
            $display("FAIL midrst_pre: lcd_e %b, required 1", bus.lcd_e);
            miscompares++;
        end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (bus.lcd_e !== 1'b0 || bus.req_ready !== 1'b0) begin
            $display("FAIL midrst_async: e/ready %b/%b, required 0/0", bus.lcd_e, bus.req_ready);
            miscompares++;
        end
        vectors++;
        if (bus.cursor !== 5'd0 || bus.lcd_db !== 8'h00) begin
            $display("FAIL midrst_state: cursor %0d db %h, required 0 00", bus.cursor, bus.lcd_db);
            miscompares++;
        end
        repeat (2) tick();
        check_release();
        clear_q();
        send_timed(8'h62, 1'b1, 8, "after_rst");
        vectors++;
        if (bus.cursor !== 5'd1) begin
            $display("FAIL after_rst_cursor: cursor %0d, required 1", bus.cursor);
            miscompares++;
        end
    endtask

    initial begin
        test_reset();
        test_data_write();
        test_line_wrap();
        test_clear_and_addr();
        test_back_to_back();
        test_reset_mid_pulse();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/lcd_write_ctrl.md
LCD_WRITE_CTRL -- requirements
Module: lcd_write_ctrl

Interface
REQ-001 SHALL have parameter E_PULSE_CYC, default 12, lcd_e high-time in clk cycles.
REQ-002 SHALL have parameter CMD_WAIT_CYC, default 2000, post-write wait for ordinary commands and data.
REQ-003 SHALL have parameter CLR_WAIT_CYC, default 82000, post-write wait for clear (0x01) and home (0x02).
REQ-004 SHALL have parameter PWR_WAIT_CYC, default 750000, power-up wait before init.
REQ-005 SHALL have ports: clk in 1, system clock; rst_n in 1, asynchronous active-low reset; req_valid in 1, request present; req_ready out 1, controller can accept; req_data in 8, byte to write; req_rs in 1, 1=data, 0=command; lcd_db out 8, LCD data bus; lcd_rs out 1, register select; lcd_rw out 1, read/write (tied 0); lcd_e out 1, enable strobe; busy out 1, equal to !req_ready; cursor out 5, current character position 0..31.

Function
REQ-006 SHALL implement states PWR_WAIT, INIT, IDLE, SETUP, PULSE, HOLD, WAIT, AUTO.
REQ-007 SHALL assert req_ready only in IDLE; a transfer SHALL occur when req_valid and req_ready are both high at a rising clk edge, capturing req_data and req_rs.
REQ-008 SHALL, for a transfer accepted at edge T: drive lcd_db/lcd_rs in SETUP during cycle T+1; hold lcd_e=1 for E_PULSE_CYC cycles from T+2; be in HOLD with lcd_e=0 for one cycle; then WAIT for the applicable wait count; then return to IDLE, with req_ready=1 at T+3+E_PULSE_CYC+wait.
REQ-009 SHALL keep lcd_db and lcd_rs stable from SETUP through HOLD inclusive.
REQ-010 SHALL, after a data write (rs=1), increment cursor modulo 32.
REQ-011 SHALL, when a data write leaves cursor at 16, enter AUTO and issue command 0xC0 through SETUP/PULSE/HOLD/WAIT before returning to IDLE; when cursor wraps to 0, SHALL issue 0x80 the same way.
REQ-012 SHALL, on command 0x01 or 0x02, set cursor=0 and use CLR_WAIT_CYC.
REQ-013 SHALL, on a command with bit7=1 (set DDRAM address), set cursor={data[6],data[3:0]}.
REQ-014 SHALL leave cursor unchanged for all other commands.
REQ-015 SHALL ignore req_valid outside IDLE; req_data and req_rs changes after acceptance SHALL have no effect.
REQ-016 SHALL select the wait count from the captured byte, including for auto-issued commands (CMD_WAIT_CYC).

Reset
REQ-017 SHALL, while rst_n=0, force lcd_e=0, lcd_rs=0, lcd_rw=0, lcd_db=8'h00, req_ready=0, cursor=0, and state PWR_WAIT (or IDLE per REQ-020).
REQ-018 SHALL drop lcd_e immediately on asynchronous reset assertion mid-pulse, and SHALL abandon any in-progress sequence.

Configuration
REQ-019 SHALL, with LCD_INIT_SEQ_EN defined: after reset, wait PWR_WAIT_CYC in PWR_WAIT, then issue 0x38, 0x38, 0x38, 0x0C, 0x06, 0x01 via the REQ-008 path (0x01 with CLR_WAIT_CYC), then enter IDLE with cursor=0.
REQ-020 SHALL, without LCD_INIT_SEQ_EN: leave reset directly into IDLE, with req_ready=1 in the first cycle after rst_n deasserts.

Structure
REQ-021 SHALL place the state enum, init command table, and constants CMD_CLEAR=8'h01, CMD_HOME=8'h02, CMD_LINE1=8'h80, and CMD_LINE2=8'hC0 in package lcd_pkg.
REQ-022 SHALL use one sub-module, lcd_timer: a loadable down-counter with a done flag, shared by PWR_WAIT, PULSE, and WAIT.

Verification (bench params E_PULSE_CYC=2, CMD_WAIT_CYC=4, CLR_WAIT_CYC=10, PWR_WAIT_CYC=20)
REQ-023 SHALL cover: init enabled, reset release -> lcd_e stays 0 for 20 cycles, then six E pulses with db 38,38,38,0C,06,01, then req_ready=1 and cursor=0.
REQ-024 SHALL cover: data 0x61 accepted at T -> lcd_e high at T+2,T+3; low at T+4; req_ready=1 at T+9; cursor +1.
REQ-025 SHALL cover: 16 data writes from cursor 0 -> after the 16th, an automatic 0xC0 pulse with lcd_rs=0, cursor=16; 16 more writes -> auto 0x80 pulse, cursor=0.
REQ-026 SHALL cover: command 0x01 at cursor 7 -> cursor=0; WAIT lasts 10 cycles; command 0xC5 -> cursor=21.
REQ-027 SHALL cover: req_valid held high with changing req_data during a write -> exactly one pulse per IDLE acceptance, with latched byte unchanged on lcd_db.
REQ-028 SHALL cover: rst_n asserted during PULSE -> lcd_e=0 and req_ready=0 in the same cycle; sequence restarts per REQ-019/REQ-020.
